serial_checking_sink: RTL and testbench
=======================================

# serial_checking_sink

Downstream endpoint for one router output port. It receives serial flits from the router's tx side and deserializes them, throttling the link through `channel_busy` with a programmable acceptance rate. Each received flit is checked against the sink's own node id, and good/misrouted flits are counted. It stands in for a node's ejection interface in single-router and mesh benches, and the counters make routing errors self-reporting.

## Interface
- `id`, 0: node id this sink represents; compared against the flit destination field.
- `flit_width`, 8: flit payload bits per serial frame; minimum 4.
- `addr_bits`, 4: width of the destination field, which is `flit[addr_bits-1:0]`; must not exceed `flit_width`.
- `hospitality`, 255: acceptance threshold, 0..255; 255 means never throttle.
- `seed`, 8'hA5: non-zero initial state of the throttle LFSR.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `serial_in` in 1: serial data from router tx.
- `channel_busy` out 1: backpressure to router tx; registered.
- `flit_valid` out 1: one-cycle pulse when a complete flit is latched.
- `flit_out` out `flit_width`: last received flit; holds its value between pulses.
- `good_count` out 16: flits whose destination equals `id`.
- `bad_count` out 16: flits whose destination does not equal `id`.
- `misroute` out 1: sticky flag, set on the first bad flit.

## Operation
- Serial frame: the line idles at 0. A 1 on `serial_in` while in IDLE is the start bit. It is followed by `flit_width` data bits, LSB first, one per cycle.
- FSM states: IDLE, SHIFT, CHECK, HOLD.
  - IDLE: `channel_busy`=0. If `serial_in`=1, clear the bit counter and go to SHIFT.
  - SHIFT: shift `serial_in` into the shift register MSB-side, so the first bit lands at bit 0 after the full frame. Increment the bit counter. After `flit_width` bits, go to CHECK.
  - CHECK: `channel_busy`=1. Copy the shift register to `flit_out` and pulse `flit_valid`. Compare `flit[addr_bits-1:0]` with `id[addr_bits-1:0]`: on a match increment `good_count`, otherwise increment `bad_count` and set `misroute`. Then sample `draw` = LFSR value: if `draw` <= `hospitality` go to IDLE, else go to HOLD.
  - HOLD: `channel_busy`=1. The LFSR advances every cycle. Re-sample `draw` each cycle and go to IDLE when `draw` <= `hospitality`.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1. It free-runs every cycle outside reset and never reaches 0.
  - `hospitality`=0 can therefore never accept: the sink stalls permanently after the first flit. This is legal and is used for deadlock tests.
- Counters saturate at 16'hFFFF and do not wrap.
- `serial_in` is ignored in CHECK and HOLD. A transmitter driving a start bit while `channel_busy`=1 violates protocol; the sink drops those bits and does not resynchronise mid-frame.
- A 0 on the line in IDLE is idle. There is no framing error detection.

## Timing
- Reset values: `channel_busy`=0, `flit_valid`=0, `flit_out`=0, `good_count`=0, `bad_count`=0, `misroute`=0, FSM in IDLE, LFSR=`seed`, bit counter=0.
- Start bit on cycle t. Data bits on cycles t+1 .. t+`flit_width`. CHECK is cycle t+`flit_width`+1.
- In CHECK: `flit_valid`=1, `channel_busy`=1, and `flit_out` is valid in the same cycle. Counters show the new value from cycle t+`flit_width`+2.
- Minimum frame spacing with `hospitality`=255 is `flit_width`+2 cycles. The earliest next start bit is on cycle t+`flit_width`+2, when `channel_busy` has returned to 0.
- `channel_busy` is registered. The upstream tx must sample it before launching a start bit and must not start while it is 1.
- Reset asserted mid-frame: the partial flit is discarded, all outputs take their reset values immediately, and counters do not change for the aborted flit.

## Structure
- `SIZE`, `ADDR_BITS` and the direction constants live in the shared `constants.v`. This block's defaults for `flit_width`/`addr_bits` come from `SIZE`/`ADDR_BITS` when instantiated in benches.
- One sub-module, `lfsr8` (clk, reset, seed, value), shared with sources that need pseudo-random injection.
- FSM state encodings are local parameters of this block and are not shared.

## Test plan
- Single flit, `id`=4, `hospitality`=255, frame 8'h34 (dest 4) -> `flit_valid` pulse on cycle t+9, `flit_out`=8'h34, `good_count`=1, `bad_count`=0, `channel_busy` high for exactly 1 cycle.
- Misrouted flit 8'h37 -> `bad_count`=1, `misroute`=1. A following good flit 8'h04 -> `good_count`=1, and `misroute` stays 1.
- Back-to-back: 20 frames at minimum spacing of 10 cycles -> 20 `flit_valid` pulses, no dropped or corrupted flit, `good_count`=20.
- `hospitality`=0 -> after the first flit, `channel_busy` stays 1 for 1000 cycles and a start bit driven meanwhile is ignored, so counters are unchanged.
- `hospitality`=128, `seed`=8'hA5, 200 frames each sent only when busy=0 -> all 200 received; total HOLD cycles match the reference LFSR model exactly.
- Reset at cycle t+4 of a frame -> all outputs 0 from the reset edge. The next complete frame after reset release is received correctly with `good_count`=1.

Source files
------------

// File: rtl/serial_checking_sink_pkg.sv
// -----------------------------------------------------------------------------
// serial_checking_sink_pkg
// Shared constants for the router benches: default flit geometry, port
// direction codes, and the 8-bit Galois LFSR step used by lfsr8.
// -----------------------------------------------------------------------------
package serial_checking_sink_pkg;

    // Default flit geometry used when sinks/sources are instantiated in benches.
    localparam int SIZE      = 8;
    localparam int ADDR_BITS = 4;

    // Router port direction codes.
    localparam logic [2:0] DIR_NORTH = 3'd0;
    localparam logic [2:0] DIR_EAST  = 3'd1;
    localparam logic [2:0] DIR_SOUTH = 3'd2;
    localparam logic [2:0] DIR_WEST  = 3'd3;
    localparam logic [2:0] DIR_LOCAL = 3'd4;

    // Right-shifting Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // One step of the 8-bit Galois LFSR; a non-zero state never maps to zero.
    function automatic logic [7:0] lfsr8_step(input logic [7:0] cur);
        logic [7:0] nxt;
        nxt = {1'b0, cur[7:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/serial_checking_sink_lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1), loaded with `seed`
// while in reset and advancing every clock afterwards.
// Ports:
//   clk   in  1 : clock, rising edge
//   reset in  1 : asynchronous active-high reset (loads seed)
//   seed  in  8 : initial state, expected non-zero
//   value out 8 : current LFSR state (registered)
// -----------------------------------------------------------------------------
module lfsr8
    import serial_checking_sink_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] value_q;
    logic [7:0] value_d;

    // Next LFSR state.
    always_comb begin
        value_d = lfsr8_step(value_q);
    end

    // State register; a zero seed would lock the LFSR, so it is replaced by 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= (seed == 8'h00) ? 8'h01 : seed;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/serial_checking_sink.sv
// -----------------------------------------------------------------------------
// serial_checking_sink
// Ejection endpoint for one router output port. Deserializes start-bit framed
// flits (LSB first), checks the destination field against this node's id,
// counts good / misrouted flits and throttles the link via channel_busy with
// an LFSR-driven acceptance rate.
// Ports:
//   clk          in  1          : clock, rising edge
//   reset        in  1          : asynchronous active-high reset
//   serial_in    in  1          : serial line from router tx (idle 0)
//   channel_busy out 1          : registered backpressure to router tx
//   flit_valid   out 1          : one-cycle pulse when a flit is latched
//   flit_out     out flit_width : last received flit, held between pulses
//   good_count   out 16         : saturating count of correctly routed flits
//   bad_count    out 16         : saturating count of misrouted flits
//   misroute     out 1          : sticky, set by the first misrouted flit
// -----------------------------------------------------------------------------
module serial_checking_sink
    import serial_checking_sink_pkg::*;
#(
    parameter int         id          = 0,
    parameter int         flit_width  = SIZE,
    parameter int         addr_bits   = ADDR_BITS,
    parameter int         hospitality = 255,
    parameter logic [7:0] seed        = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    output logic                  channel_busy,
    output logic                  flit_valid,
    output logic [flit_width-1:0] flit_out,
    output logic [15:0]           good_count,
    output logic [15:0]           bad_count,
    output logic                  misroute
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int                   CNT_W    = $clog2(flit_width + 1);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(flit_width - 1);
    localparam logic [addr_bits-1:0] ID_ADDR  = addr_bits'(id);
    localparam logic [7:0]           HOSP     = 8'(hospitality);

    logic [1:0]            state_q,   state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    // Holds the first flit_width-1 bits; the last bit goes straight to flit_q.
    logic [flit_width-2:0] shreg_q,   shreg_d;
    logic [flit_width-1:0] flit_q,    flit_d;
    logic                  busy_q,    busy_d;
    logic                  valid_q,   valid_d;
    logic [15:0]           good_q,    good_d;
    logic [15:0]           bad_q,     bad_d;
    logic                  mis_q,     mis_d;

    logic [7:0]            draw_s;
    logic                  accept_s;
    logic                  dest_match_s;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (seed),
        .value (draw_s)
    );

    assign accept_s     = (draw_s <= HOSP);
    assign dest_match_s = (flit_q[addr_bits-1:0] == ID_ADDR);

    // Frame FSM, deserializer and counter next-state logic.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        flit_d    = flit_q;
        good_d    = good_q;
        bad_d     = bad_q;
        mis_d     = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (serial_in) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == LAST_BIT) begin
                    state_d = ST_CHECK;
                    flit_d  = {serial_in, shreg_q};
                end else begin
                    state_d = ST_SHIFT;
                    shreg_d = {serial_in, shreg_q[flit_width-2:1]};
                end
            end
            ST_CHECK: begin
                // flit_q already holds the new flit; counters update on exit.
                if (dest_match_s) begin
                    good_d = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
                end else begin
                    bad_d  = (bad_q == 16'hFFFF) ? bad_q : bad_q + 16'd1;
                    mis_d  = 1'b1;
                end
                state_d = accept_s ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                state_d = accept_s ? ST_IDLE : ST_HOLD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        busy_d  = (state_d == ST_CHECK) || (state_d == ST_HOLD);
        valid_d = (state_d == ST_CHECK);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= {CNT_W{1'b0}};
            shreg_q   <= {(flit_width-1){1'b0}};
            flit_q    <= {flit_width{1'b0}};
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            good_q    <= 16'd0;
            bad_q     <= 16'd0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            flit_q    <= flit_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            mis_q     <= mis_d;
        end
    end

    assign channel_busy = busy_q;
    assign flit_valid   = valid_q;
    assign flit_out     = flit_q;
    assign good_count   = good_q;
    assign bad_count    = bad_q;
    assign misroute     = mis_q;

endmodule

// File: tb/tb_serial_checking_sink.sv
// -----------------------------------------------------------------------------
// tb_serial_checking_sink
// Three sinks (id 4): A with hospitality 255, Z with hospitality 0, H with
// hospitality 128 / seed A5. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_checking_sink;

    logic        clk = 1'b0;
    logic        rst_a, rst_z, rst_h;
    logic        ser_a, ser_z, ser_h;
    logic        busy_a, valid_a, mis_a;
    logic        busy_z, valid_z, mis_z;
    logic        busy_h, valid_h, mis_h;
    logic [7:0]  flit_a, flit_z, flit_h;
    logic [15:0] good_a, bad_a, good_z, bad_z, good_h, bad_h;

    int checks   = 0;
    int failures = 0;
    int pulses_a = 0;
    int pulses_z = 0;
    int pulses_h = 0;
    int hold_h   = 0;
    int cyc_h    = 0;

    // Reference LFSR sequence: seq[n] is the state n clocks after reset release.
    logic [7:0] seq [0:8191];

    always #5 clk = ~clk;

    serial_checking_sink #(.id(4), .flit_width(8), .addr_bits(4),
                           .hospitality(255), .seed(8'hA5)) dut_a (
        .clk(clk), .reset(rst_a), .serial_in(ser_a), .channel_busy(busy_a),
        .flit_valid(valid_a), .flit_out(flit_a), .good_count(good_a),
        .bad_count(bad_a), .misroute(mis_a));

    serial_checking_sink #(.id(4), .flit_width(8), .addr_bits(4),
                           .hospitality(0), .seed(8'h5A)) dut_z (
        .clk(clk), .reset(rst_z), .serial_in(ser_z), .channel_busy(busy_z),
        .flit_valid(valid_z), .flit_out(flit_z), .good_count(good_z),
        .bad_count(bad_z), .misroute(mis_z));

    serial_checking_sink #(.id(4), .flit_width(8), .addr_bits(4),
                           .hospitality(128), .seed(8'hA5)) dut_h (
        .clk(clk), .reset(rst_h), .serial_in(ser_h), .channel_busy(busy_h),
        .flit_valid(valid_h), .flit_out(flit_h), .good_count(good_h),
        .bad_count(bad_h), .misroute(mis_h));

    // Pulse and HOLD-cycle tallies observed on the falling edge.
    always @(negedge clk) begin
        if (valid_a) pulses_a <= pulses_a + 1;
        if (valid_z) pulses_z <= pulses_z + 1;
        if (valid_h) pulses_h <= pulses_h + 1;
        if (busy_h && !valid_h) hold_h <= hold_h + 1;
    end

    // Clocks elapsed since H left reset, used to index the LFSR sequence.
    always @(posedge clk or posedge rst_h) begin
        if (rst_h) cyc_h <= 0;
        else       cyc_h <= cyc_h + 1;
    end

    function automatic logic [7:0] galois_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input logic b);
        case (which)
            0:       ser_a = b;
            1:       ser_z = b;
            default: ser_h = b;
        endcase
    endtask

    task automatic set_rst(input int which, input logic b);
        case (which)
            0:       rst_a = b;
            1:       rst_z = b;
            default: rst_h = b;
        endcase
    endtask

    task automatic reset_pulse(input int which);
        set_rst(which, 1'b1);
        repeat (2) @(negedge clk);
        set_rst(which, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Start bit then 8 data bits LSB first; returns on the falling edge of CHECK.
    task automatic send(input int which, input logic [7:0] d);
        drive(which, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            @(negedge clk);
        end
        drive(which, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] v;
        logic       exp_mis;
        int         p0, h0, n, exp_good, exp_bad, exp_hold, wait_cnt, busy_cnt;

        rst_a = 1'b1; rst_z = 1'b1; rst_h = 1'b1;
        ser_a = 1'b0; ser_z = 1'b0; ser_h = 1'b0;
        seq[0] = 8'hA5;
        for (int i = 1; i < 8192; i++) seq[i] = galois_next(seq[i-1]);
        repeat (2) @(negedge clk);

        // Reset state
        check_eq("rst_busy",  32'(busy_a),  32'd0);
        check_eq("rst_valid", 32'(valid_a), 32'd0);
        check_eq("rst_flit",  32'(flit_a),  32'd0);
        check_eq("rst_good",  32'(good_a),  32'd0);
        check_eq("rst_bad",   32'(bad_a),   32'd0);
        check_eq("rst_mis",   32'(mis_a),   32'd0);
        rst_a = 1'b0; rst_z = 1'b0; rst_h = 1'b0;
        repeat (2) @(negedge clk);

        // Single good flit
        send(0, 8'h34);
        check_eq("t1_valid", 32'(valid_a), 32'd1);
        check_eq("t1_flit",  32'(flit_a),  32'h34);
        check_eq("t1_busy",  32'(busy_a),  32'd1);
        check_eq("t1_good_pre", 32'(good_a), 32'd0);
        @(negedge clk);
        check_eq("t1_good",  32'(good_a),  32'd1);
        check_eq("t1_bad",   32'(bad_a),   32'd0);
        check_eq("t1_busy_off",  32'(busy_a),  32'd0);
        check_eq("t1_valid_off", 32'(valid_a), 32'd0);
        check_eq("t1_flit_hold", 32'(flit_a),  32'h34);

        // Misrouted then good flit
        reset_pulse(0);
        send(0, 8'h37);
        @(negedge clk);
        check_eq("t2_bad",  32'(bad_a),  32'd1);
        check_eq("t2_mis",  32'(mis_a),  32'd1);
        check_eq("t2_good0", 32'(good_a), 32'd0);
        send(0, 8'h04);
        check_eq("t2_flit", 32'(flit_a), 32'h04);
        @(negedge clk);
        check_eq("t2_good", 32'(good_a), 32'd1);
        check_eq("t2_mis_sticky", 32'(mis_a), 32'd1);

        // Back-to-back at minimum spacing
        reset_pulse(0);
        p0 = pulses_a;
        for (int f = 0; f < 20; f++) begin
            d = {4'($urandom_range(0, 15)), 4'h4};
            send(0, d);
            check_eq("b2b_flit", 32'(flit_a), 32'(d));
            @(negedge clk);
            check_eq("b2b_idle", 32'(busy_a), 32'd0);
        end
        repeat (2) @(negedge clk);
        check_eq("b2b_good",   32'(good_a), 32'd20);
        check_eq("b2b_bad",    32'(bad_a),  32'd0);
        check_eq("b2b_pulses", 32'(pulses_a - p0), 32'd20);

        // Random mixed destinations with random gaps
        reset_pulse(0);
        exp_good = 0; exp_bad = 0; exp_mis = 1'b0;
        for (int f = 0; f < 30; f++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) d[3:0] = 4'h4;
            if (d[3:0] == 4'h4) exp_good++;
            else begin exp_bad++; exp_mis = 1'b1; end
            send(0, d);
            check_eq("rnd_flit", 32'(flit_a), 32'(d));
            @(negedge clk);
            check_eq("rnd_good", 32'(good_a), 32'(exp_good));
            check_eq("rnd_bad",  32'(bad_a),  32'(exp_bad));
            check_eq("rnd_mis",  32'(mis_a),  32'(exp_mis));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a frame
        ser_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ser_a = i[0];
            @(negedge clk);
        end
        rst_a = 1'b1;
        #1;
        check_eq("mid_busy",  32'(busy_a),  32'd0);
        check_eq("mid_valid", 32'(valid_a), 32'd0);
        check_eq("mid_flit",  32'(flit_a),  32'd0);
        check_eq("mid_good",  32'(good_a),  32'd0);
        check_eq("mid_bad",   32'(bad_a),   32'd0);
        check_eq("mid_mis",   32'(mis_a),   32'd0);
        ser_a = 1'b0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        send(0, 8'hA4);
        check_eq("post_flit", 32'(flit_a), 32'hA4);
        @(negedge clk);
        check_eq("post_good", 32'(good_a), 32'd1);
        check_eq("post_bad",  32'(bad_a),  32'd0);

        // hospitality 0: permanent stall after the first flit
        send(1, 8'h04);
        check_eq("z_busy",  32'(busy_z),  32'd1);
        check_eq("z_valid", 32'(valid_z), 32'd1);
        busy_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 100)                ser_z = 1'b1;
            else if (i > 100 && i < 109) ser_z = (i == 103);
            else                         ser_z = 1'b0;
            @(negedge clk);
            if (busy_z) busy_cnt++;
        end
        ser_z = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("z_busy_cycles", 32'(busy_cnt), 32'd1000);
        check_eq("z_good",   32'(good_z),   32'd1);
        check_eq("z_bad",    32'(bad_z),    32'd0);
        check_eq("z_flit",   32'(flit_z),   32'h04);
        check_eq("z_pulses", 32'(pulses_z), 32'd1);

        // hospitality 128: HOLD cycles against the reference LFSR sequence
        reset_pulse(2);
        h0 = hold_h; p0 = pulses_h;
        exp_good = 0; exp_bad = 0; exp_hold = 0;
        for (int f = 0; f < 200; f++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) d[3:0] = 4'h4;
            if (d[3:0] == 4'h4) exp_good++;
            else exp_bad++;
            send(2, d);
            check_eq("h_flit", 32'(flit_h), 32'(d));
            n = cyc_h;
            v = seq[n];
            while (v > 8'd128 && n < 8191) begin
                exp_hold++;
                n++;
                v = seq[n];
            end
            wait_cnt = 0;
            do begin
                @(negedge clk);
                wait_cnt++;
            end while (busy_h && wait_cnt < 300);
            check_eq("h_release", 32'(busy_h), 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check_eq("h_good",   32'(good_h), 32'(exp_good));
        check_eq("h_bad",    32'(bad_h),  32'(exp_bad));
        check_eq("h_pulses", 32'(pulses_h - p0), 32'd200);
        check_eq("h_holds",  32'(hold_h - h0),   32'(exp_hold));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
